// File: rtl/forth_dbus_io_pkg.sv
// Shared constants for the forth data-bus responder: address map, status bit
// positions and the UART transmitter state encoding.
package forth_io_pkg;

    localparam logic [7:0] A_UART_DATA = 8'h80;
    localparam logic [7:0] A_UART_STAT = 8'h81;
    localparam logic [7:0] A_TIMER     = 8'h82;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/forth_dbus_io_if.sv
// Data-bus port between the forth core (master) and its I/O responder (slave).
interface forth_dbus_io_if #(
    parameter int width       = 16,
    parameter int daddr_width = 8
);
    // No valid/ready pair: every rising edge is an access. dwrite is sampled on
    // each edge, and ddata_read carries the answer for the daddr sampled on the
    // previous edge; the slave never stalls.
    logic [daddr_width-1:0] daddr;
    logic [width-1:0]       ddata_write;
    logic                   dwrite;
    logic [width-1:0]       ddata_read;

    modport master (output daddr, output ddata_write, output dwrite, input ddata_read);
    modport slave  (input daddr, input ddata_write, input dwrite, output ddata_read);
endinterface

// File: rtl/forth_uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 LSB-first UART transmitter; the FSM state is
// exported for debug.
module forth_uart_tx_fifo
    import forth_io_pkg::*;
#(
    parameter int fifo_depth = 8,
    parameter int baud_div   = 16
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic [7:0] data,
    input  logic      clr_overflow,
    output logic      full,
    output logic      empty,
    output logic      busy,
    output logic      overflow,
    output logic      tx,
    output tx_state_t state
);
    localparam int aw = $clog2(fifo_depth);
    localparam int cw = $clog2(baud_div);
    localparam logic [aw:0]   depth_c = (aw + 1)'(fifo_depth);
    localparam logic [cw-1:0] baud_load = cw'(baud_div - 1);

    logic [7:0]    mem [fifo_depth];
    logic [aw-1:0] wr_ptr, rd_ptr;
    logic [aw:0]   count;
    logic          pop, push_ok;

    tx_state_t     state_next;
    logic [cw-1:0] baud_cnt, baud_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    shreg, sh_next;

    assign full  = (count == depth_c);
    assign empty = (count == '0);
    assign busy  = (state != TX_IDLE);
    assign pop   = (state == TX_IDLE) && !empty;
    // A pop in the same edge frees the slot, so a push to a full FIFO still lands.
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !push_ok) overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shreg    <= sh_next;
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        sh_next    = shreg;
        tx         = 1'b1;
        case (state)
            TX_IDLE: begin
                if (!empty) begin
                    state_next = TX_START;
                    baud_next  = baud_load;
                    sh_next    = mem[rd_ptr];
                end
            end
            TX_START: begin
                tx = 1'b0;
                if (baud_cnt == '0) begin
                    state_next = TX_DATA;
                    baud_next  = baud_load;
                    bit_next   = '0;
                end else begin
                    baud_next = baud_cnt - 1'b1;
                end
            end
            TX_DATA: begin
                tx = shreg[0];
                if (baud_cnt == '0) begin
                    baud_next = baud_load;
                    sh_next   = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) state_next = TX_STOP;
                    else                 bit_next   = bit_idx + 1'b1;
                end else begin
                    baud_next = baud_cnt - 1'b1;
                end
            end
            TX_STOP: begin
                if (baud_cnt == '0) state_next = TX_IDLE;
                else                baud_next  = baud_cnt - 1'b1;
            end
            default: state_next = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/forth_dbus_io.sv
// Data-bus responder for the forth core: data RAM, UART TX with FIFO and a
// free-running timer, all answered with one cycle of registered read latency.
module forth_dbus_io
    import forth_io_pkg::*;
#(
    parameter int width       = 16,
    parameter int daddr_width = 8,
    parameter int ram_depth   = 128,
    parameter int fifo_depth  = 8,
    parameter int baud_div    = 16
) (
    input  logic            clk,
    input  logic            reset,
    forth_dbus_io_if.slave  bus,
    output logic            uart_tx,
    output tx_state_t       tx_state
);
    localparam int ram_aw = $clog2(ram_depth);
    localparam logic [daddr_width-1:0] addr_data  = daddr_width'(A_UART_DATA);
    localparam logic [daddr_width-1:0] addr_stat  = daddr_width'(A_UART_STAT);
    localparam logic [daddr_width-1:0] addr_timer = daddr_width'(A_TIMER);

    logic [width-1:0]  ram [ram_depth];
    logic [ram_aw-1:0] ram_idx;
    logic [width-1:0]  timer, timer_next, rd_data;
    logic              ram_sel, ram_we, uart_push, stat_wr, timer_wr;
    logic              fifo_full, fifo_empty, tx_busy, overflow;

    assign ram_idx   = bus.daddr[ram_aw-1:0];
    assign ram_sel   = !bus.daddr[daddr_width-1] && (int'(bus.daddr) < ram_depth);
    assign ram_we    = bus.dwrite && ram_sel;
    assign uart_push = bus.dwrite && (bus.daddr == addr_data);
    assign stat_wr   = bus.dwrite && (bus.daddr == addr_stat) && bus.ddata_write[ST_OVF];
    assign timer_wr  = bus.dwrite && (bus.daddr == addr_timer);
    assign timer_next = timer_wr ? bus.ddata_write : timer + 1'b1;

    forth_uart_tx_fifo #(
        .fifo_depth (fifo_depth),
        .baud_div   (baud_div)
    ) u_tx (
        .clk          (clk),
        .reset        (reset),
        .push         (uart_push),
        .data         (bus.ddata_write[7:0]),
        .clr_overflow (stat_wr),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .busy         (tx_busy),
        .overflow     (overflow),
        .tx           (uart_tx),
        .state        (tx_state)
    );

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_idx] <= bus.ddata_write;
    end

    // RAM reads see the pre-edge word (read-before-write); timer reads return the
    // count the register holds after the sampling edge.
    always_comb begin
        rd_data = '0;
        if (ram_sel) begin
            rd_data = ram[ram_idx];
        end else if (bus.daddr == addr_stat) begin
            rd_data[ST_FULL]  = fifo_full;
            rd_data[ST_EMPTY] = fifo_empty;
            rd_data[ST_BUSY]  = tx_busy;
            rd_data[ST_OVF]   = overflow;
        end else if (bus.daddr == addr_timer) begin
            rd_data = timer_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer          <= '0;
            bus.ddata_read <= '0;
        end else begin
            timer          <= timer_next;
            bus.ddata_read <= rd_data;
        end
    end

endmodule

// File: tb/tb_forth_dbus_io.sv
// Directed bench for forth_dbus_io: RAM, UART framing/FIFO overflow, timer wrap,
// unmapped addresses and reset mid-frame.
module tb_forth_dbus_io;
    import forth_io_pkg::*;

    localparam int baud      = 4;
    localparam int frame_cyc = 10 * baud + 1;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    logic      uart_tx;
    tx_state_t tx_state;

    forth_dbus_io_if #(.width(16), .daddr_width(8)) bus ();

    forth_dbus_io #(
        .width       (16),
        .daddr_width (8),
        .ram_depth   (128),
        .fifo_depth  (8),
        .baud_div    (baud)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .bus      (bus.slave),
        .uart_tx  (uart_tx),
        .tx_state (tx_state)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n++;

    int         n_checks = 0;
    int         n_fail = 0;
    int         frame_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         start_q[$];
    logic [15:0] rd;

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic bus_write(logic [7:0] a, logic [15:0] d);
        bus.daddr = a;
        bus.ddata_write = d;
        bus.dwrite = 1'b1;
        step();
        bus.dwrite = 1'b0;
    endtask

    task automatic bus_read(logic [7:0] a, output logic [15:0] d);
        bus.daddr = a;
        bus.dwrite = 1'b0;
        step();
        d = bus.ddata_read;
    endtask

    task automatic wait_rx(int n, int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check("rx_count", 16'(rx_q.size()), 16'(n));
    endtask

    task automatic mon_wait(int k, inout bit ab);
        repeat (k) begin
            @(negedge clk);
            if (rst_n !== 1'b1) ab = 1'b1;
        end
    endtask

    // Serial monitor: decodes frames mid-bit and drops any frame cut by reset.
    initial begin
        logic [7:0] b;
        bit bad, ab;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && uart_tx === 1'b0) begin
                start_q.push_back(cyc_n);
                ab = 1'b0;
                bad = 1'b0;
                b = '0;
                mon_wait(2, ab);
                if (uart_tx !== 1'b0) bad = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    mon_wait(baud, ab);
                    b[i] = uart_tx;
                end
                mon_wait(baud, ab);
                if (uart_tx !== 1'b1) bad = 1'b1;
                if (!ab) begin
                    if (bad) frame_err++;
                    else rx_q.push_back(b);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.daddr = '0;
        bus.ddata_write = '0;
        bus.dwrite = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ddata_read", bus.ddata_read, 16'h0000);
        check("rst_uart_tx", 16'(uart_tx), 16'h0001);
        check("rst_tx_state", 16'(tx_state), 16'(TX_IDLE));
        rst_n = 1'b1;
        step();
        bus_read(8'h81, rd);
        check("rst_status", rd, 16'h0002);

        // RAM round trip, then read-before-write on the same address.
        bus_write(8'h05, 16'h1234);
        bus_read(8'h05, rd);
        check("ram_rd", rd, 16'h1234);
        bus_write(8'h05, 16'hBEEF);
        check("ram_rw_old", bus.ddata_read, 16'h1234);
        bus_read(8'h05, rd);
        check("ram_rw_new", rd, 16'hBEEF);
        bus_read(8'h80, rd);
        check("uart_data_rd", rd, 16'h0000);
        bus_read(8'h05, rd);
        bus_read(8'h90, rd);
        check("unmapped_rd", rd, 16'h0000);

        // Timer wrap after a load.
        bus_write(8'h82, 16'hFFFE);
        bus_read(8'h82, rd);
        check("timer_ffff", rd, 16'hFFFF);
        bus_read(8'h82, rd);
        check("timer_wrap", rd, 16'h0000);

        // Single UART byte.
        rx_q.delete();
        start_q.delete();
        bus_write(8'h80, 16'h00A5);
        idle(10);
        bus_read(8'h81, rd);
        check("stat_busy", rd, 16'h0006);
        wait_rx(1, 100);
        if (rx_q.size() >= 1) check("rx_a5", 16'(rx_q[0]), 16'h00A5);
        idle(3);
        bus_read(8'h81, rd);
        check("stat_idle", rd, 16'h0002);

        // Overflow: first byte is popped at once, next eight fill the FIFO, tenth drops.
        rx_q.delete();
        start_q.delete();
        exp_q.delete();
        for (int v = 1; v <= 10; v++) begin
            bus_write(8'h80, 16'(v));
            if (v <= 9) exp_q.push_back(8'(v));
        end
        bus_read(8'h81, rd);
        check("stat_ovf_full", rd, 16'h000D);
        bus_write(8'h81, 16'h0008);
        bus_read(8'h81, rd);
        check("stat_ovf_clr", rd, 16'h0005);
        wait_rx(9, 600);
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("rx_byte%0d", i), 16'(rx_q[i]), 16'(exp_q[i]));
        for (int i = 1; i < start_q.size() && i < 9; i++)
            check($sformatf("frame_gap%0d", i), 16'(start_q[i] - start_q[i-1]), 16'(frame_cyc));
        idle(3);
        bus_read(8'h81, rd);
        check("stat_drained", rd, 16'h0002);
        idle(20);
        check("no_dropped_byte", 16'(rx_q.size()), 16'd9);
        check("frame_err", 16'(frame_err), 16'd0);

        // Reset in the middle of the data bits of 0x3C (first data bit is 0).
        bus_write(8'h10, 16'h5A5A);
        rx_q.delete();
        bus_write(8'h80, 16'h003C);
        idle(8);
        check("pre_rst_state", 16'(tx_state), 16'(TX_DATA));
        check("pre_rst_tx", 16'(uart_tx), 16'h0000);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 16'(uart_tx), 16'h0001);
        check("mid_rst_rd", bus.ddata_read, 16'h0000);
        idle(2);
        rst_n = 1'b1;
        step();
        bus_read(8'h81, rd);
        check("post_rst_status", rd, 16'h0002);
        bus_read(8'h10, rd);
        check("ram_retained", rd, 16'h5A5A);
        bus_write(8'h90, 16'hFFFF);
        bus_read(8'h10, rd);
        check("unmapped_wr_ignored", rd, 16'h5A5A);
        idle(50);
        check("abandoned_frame", 16'(rx_q.size()), 16'd0);
        check("post_rst_idle_tx", 16'(uart_tx), 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
